// File: rtl/img_pkg.sv
// Shared pixel types and default geometry/weights for the gray feeder
// and the downstream edge detector.
package img_pkg;

  typedef logic [23:0] pixel_t;
  typedef logic [7:0]  gray_t;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } marks_t;

  localparam int H_PIX_DEF = 640;
  localparam int V_PIX_DEF = 480;
  // Luma weights in 1/256 units; they must sum to 256 so white maps to 0xFF.
  localparam int W_R_DEF   = 77;
  localparam int W_G_DEF   = 150;
  localparam int W_B_DEF   = 29;

endpackage

// File: rtl/pix_coord_counter.sv
// Column/row tracker for an accepted pixel stream; flags describe the pixel
// being accepted this cycle, sof_in forces that pixel to (0,0).
module pix_coord_counter
  import img_pkg::*;
#(
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_PIX = V_PIX_DEF,
  parameter int CW    = $clog2(H_PIX),
  parameter int RW    = (V_PIX > 1) ? $clog2(V_PIX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          sof_in,
  output logic [CW-1:0] pos_col,
  output logic [RW-1:0] pos_row,
  output logic          sol,
  output logic          eol,
  output logic          sof,
  output logic          eof
);

  localparam logic [CW-1:0] COL_LAST = CW'(H_PIX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_PIX - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    pos_col = sof_in ? '0 : col_q;
    pos_row = sof_in ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (adv) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end
  end

  assign sol = (pos_col == '0);
  assign eol = (pos_col == COL_LAST);
  assign sof = sol && (pos_row == '0);
  assign eof = eol && (pos_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/rgb_to_gray_stream.sv
// RGB-to-luma converter feeding the edge detector: two-stage weighted-sum
// pipeline with ready/valid flow control and line/frame markers.
module rgb_to_gray_stream
  import img_pkg::*;
#(
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_PIX = V_PIX_DEF,
  parameter int W_R   = W_R_DEF,
  parameter int W_G   = W_G_DEF,
  parameter int W_B   = W_B_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  pixel_t pix_in,
  input  logic   in_valid,
  input  logic   sof_in,
  output logic   in_ready,
  output pixel_t pix_out,
  output logic   out_valid,
  input  logic   out_ready,
  output logic   sol,
  output logic   eol,
  output logic   sof,
  output logic   eof
);

  localparam int CW = $clog2(H_PIX);
  localparam int RW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

  logic          stall;
  logic          accept;
  marks_t        pos_marks;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          unused_pos;

  logic          s1_valid_q, s1_valid_d;
  logic [15:0]   pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  marks_t        s1_marks_q, s1_marks_d;
  logic          out_valid_q, out_valid_d;
  pixel_t        pix_q, pix_d;
  marks_t        out_marks_q, out_marks_d;
  logic [15:0]   sum;
  gray_t         y;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

  pix_coord_counter #(
    .H_PIX (H_PIX),
    .V_PIX (V_PIX),
    .CW    (CW),
    .RW    (RW)
  ) u_coord (
    .clk     (clk),
    .rst     (rst),
    .adv     (accept),
    .sof_in  (sof_in),
    .pos_col (pos_col),
    .pos_row (pos_row),
    .sol     (pos_marks.sol),
    .eol     (pos_marks.eol),
    .sof     (pos_marks.sof),
    .eof     (pos_marks.eof)
  );

  // Raw position is exported by the counter for debug taps; only the flags travel down the pipe.
  assign unused_pos = ^{pos_col, pos_row};

  // Weights sum to 256, so the 16-bit sum cannot overflow (max 255*256).
  assign sum = pr_q + pg_q + pb_q;
  assign y   = sum[15:8];

  always_comb begin
    s1_valid_d  = s1_valid_q;
    pr_d        = pr_q;
    pg_d        = pg_q;
    pb_d        = pb_q;
    s1_marks_d  = s1_marks_q;
    out_valid_d = out_valid_q;
    pix_d       = pix_q;
    out_marks_d = out_marks_q;
    if (!stall) begin
      s1_valid_d  = accept;
      pr_d        = 16'(pix_in[23:16]) * 16'(W_R);
      pg_d        = 16'(pix_in[15:8])  * 16'(W_G);
      pb_d        = 16'(pix_in[7:0])   * 16'(W_B);
      s1_marks_d  = accept ? pos_marks : '0;
      out_valid_d = s1_valid_q;
      pix_d       = {y, y, y};
      out_marks_d = s1_valid_q ? s1_marks_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      pr_q        <= '0;
      pg_q        <= '0;
      pb_q        <= '0;
      s1_marks_q  <= '0;
      out_valid_q <= 1'b0;
      pix_q       <= '0;
      out_marks_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      pr_q        <= pr_d;
      pg_q        <= pg_d;
      pb_q        <= pb_d;
      s1_marks_q  <= s1_marks_d;
      out_valid_q <= out_valid_d;
      pix_q       <= pix_d;
      out_marks_q <= out_marks_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pix_out   = pix_q;
  assign sol       = out_marks_q.sol;
  assign eol       = out_marks_q.eol;
  assign sof       = out_marks_q.sof;
  assign eof       = out_marks_q.eof;

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed bench for rgb_to_gray_stream on a 4x2 frame: colour math, markers,
// backpressure, bubbles, mid-line sof_in and reset while stalled.
module tb_rgb_to_gray_stream;

  logic        clk;
  logic        rst;
  logic [23:0] pix_in;
  logic        in_valid;
  logic        sof_in;
  logic        in_ready;
  logic [23:0] pix_out;
  logic        out_valid;
  logic        out_ready;
  logic        sol, eol, sof, eof;

  int n_pass  = 0;
  int n_total = 0;

  rgb_to_gray_stream #(
    .H_PIX (4),
    .V_PIX (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .in_valid  (in_valid),
    .sof_in    (sof_in),
    .in_ready  (in_ready),
    .pix_out   (pix_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sol       (sol),
    .eol       (eol),
    .sof       (sof),
    .eof       (eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  // flags packed as {sol,eol,sof,eof}
  typedef struct {
    logic [23:0] pix;
    logic        sof_in;
    logic [23:0] exp_pix;
    logic [3:0]  exp_flags;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  logic [27:0] mon_q[$];
  bit          mon_en = 1'b0;

  always @(negedge clk)
    if (mon_en && out_valid && out_ready)
      mon_q.push_back({sol, eol, sof, eof, pix_out});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] bp_pix[5];
  logic [3:0]  bp_flags[5];
  logic        bub_v[5];
  logic [3:0]  bub_flags[5];
  int          k, hold;
  bit          seen, acc;

  initial begin
    // colour math
    tbl[0]  = '{24'hFFFFFF, 1'b1, 24'hFFFFFF, 4'b1010};
    tbl[1]  = '{24'hFF0000, 1'b0, 24'h4C4C4C, 4'b0000};
    tbl[2]  = '{24'h00FF00, 1'b0, 24'h959595, 4'b0000};
    tbl[3]  = '{24'h0000FF, 1'b0, 24'h1C1C1C, 4'b0100};
    tbl[4]  = '{24'h000000, 1'b0, 24'h000000, 4'b1000};
    // markers over a full 4x2 frame plus wrap
    tbl[5]  = '{24'h010101, 1'b1, 24'h010101, 4'b1010};
    tbl[6]  = '{24'h123456, 1'b0, 24'h2D2D2D, 4'b0000};
    tbl[7]  = '{24'h804020, 1'b0, 24'h4F4F4F, 4'b0000};
    tbl[8]  = '{24'h040404, 1'b0, 24'h040404, 4'b0100};
    tbl[9]  = '{24'h050505, 1'b0, 24'h050505, 4'b1000};
    tbl[10] = '{24'h060606, 1'b0, 24'h060606, 4'b0000};
    tbl[11] = '{24'h070707, 1'b0, 24'h070707, 4'b0000};
    tbl[12] = '{24'h080808, 1'b0, 24'h080808, 4'b0101};
    tbl[13] = '{24'h090909, 1'b0, 24'h090909, 4'b1010};
    // sof_in at column 2 of row 1
    tbl[14] = '{24'h202020, 1'b1, 24'h202020, 4'b1010};
    tbl[15] = '{24'h212121, 1'b0, 24'h212121, 4'b0000};
    tbl[16] = '{24'h222222, 1'b0, 24'h222222, 4'b0000};
    tbl[17] = '{24'h232323, 1'b0, 24'h232323, 4'b0100};
    tbl[18] = '{24'h242424, 1'b0, 24'h242424, 4'b1000};
    tbl[19] = '{24'h252525, 1'b0, 24'h252525, 4'b0000};
    tbl[20] = '{24'h262626, 1'b1, 24'h262626, 4'b1010};
    tbl[21] = '{24'h272727, 1'b0, 24'h272727, 4'b0000};
    tbl[22] = '{24'h282828, 1'b0, 24'h282828, 4'b0000};
    tbl[23] = '{24'h292929, 1'b0, 24'h292929, 4'b0100};

    bp_pix   = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    bp_flags = '{4'b1010, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
    bub_v     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bub_flags = '{4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0100};

    rst = 1'b1; pix_in = '0; in_valid = 1'b0; sof_in = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pix_out", 32'(pix_out), 32'd0);
    chk("rst_flags", 32'({sol, eol, sof, eof}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        in_valid = 1'b1; pix_in = tbl[i].pix; sof_in = tbl[i].sof_in;
      end else begin
        in_valid = 1'b0; sof_in = 1'b0;
      end
      tick();
      if (i == 0) begin
        chk("tbl_latency_empty", 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("tbl%0d_valid", i-1), 32'(out_valid), 32'd1);
        chk($sformatf("tbl%0d_pix", i-1), 32'(pix_out), 32'(tbl[i-1].exp_pix));
        chk($sformatf("tbl%0d_flags", i-1), 32'({sol, eol, sof, eof}), 32'(tbl[i-1].exp_flags));
        chk($sformatf("tbl%0d_in_ready", i-1), 32'(in_ready), 32'd1);
      end
    end
    tick();
    chk("tbl_drain_valid", 32'(out_valid), 32'd0);
    chk("tbl_drain_flags", 32'({sol, eol, sof, eof}), 32'd0);

    // backpressure: 3-cycle hold right after the first out_valid
    mon_q.delete(); mon_en = 1'b1; k = 0; hold = 0; seen = 1'b0;
    for (int c = 0; c < 40 && mon_q.size() < 5; c++) begin
      if (out_valid && !seen) begin
        seen = 1'b1; hold = 3;
      end
      out_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        chk($sformatf("bp_hold%0d_in_ready", hold), 32'(in_ready), 32'd0);
        chk($sformatf("bp_hold%0d_pix", hold), 32'(pix_out), 32'h111111);
        chk($sformatf("bp_hold%0d_flags", hold), 32'({sol, eol, sof, eof}), 32'b1010);
        hold--;
      end
      if (k < 5) begin
        in_valid = 1'b1; pix_in = bp_pix[k]; sof_in = (k == 0);
      end else begin
        in_valid = 1'b0; sof_in = 1'b0;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    mon_en = 1'b0;
    in_valid = 1'b0; sof_in = 1'b0; out_ready = 1'b1;
    chk("bp_count", 32'(mon_q.size()), 32'd5);
    for (int j = 0; j < 5 && j < mon_q.size(); j++)
      chk($sformatf("bp_order%0d", j), 32'(mon_q[j]), 32'({bp_flags[j], bp_pix[j]}));
    tick(); tick();

    // bubbles: in_valid 1,0,1 (then two more pixels to expose the column)
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        in_valid = bub_v[i]; pix_in = {3{8'hA0 + 8'(i)}}; sof_in = (i == 0);
      end else begin
        in_valid = 1'b0; sof_in = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("bub%0d_valid", i-1), 32'(out_valid), 32'(bub_v[i-1]));
        chk($sformatf("bub%0d_flags", i-1), 32'({sol, eol, sof, eof}), 32'(bub_flags[i-1]));
        if (bub_v[i-1])
          chk($sformatf("bub%0d_pix", i-1), 32'(pix_out), 32'({3{8'hA0 + 8'(i-1)}}));
      end
    end
    tick();

    // reset while stalled mid-line
    out_ready = 1'b0;
    in_valid = 1'b1; pix_in = 24'h303030; sof_in = 1'b1;
    tick();
    pix_in = 24'h313131; sof_in = 1'b0;
    tick();
    chk("rs_setup_valid", 32'(out_valid), 32'd1);
    chk("rs_setup_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    chk("rs_pix_out", 32'(pix_out), 32'd0);
    chk("rs_flags", 32'({sol, eol, sof, eof}), 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; pix_in = 24'h323232; sof_in = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rs_next_valid", 32'(out_valid), 32'd1);
    chk("rs_next_pix", 32'(pix_out), 32'h323232);
    chk("rs_next_flags", 32'({sol, eol, sof, eof}), 32'b1010);
    tick();
    chk("rs_dropped", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray_stream.md
Name: rgb_to_gray_stream

Overview:
- Upstream feeder for the pixel-difference edge detector.
- Converts a 24-bit RGB pixel stream to 8-bit luma, replicated on all three channels so the detector's top nibble carries true intensity rather than red only.
- Tracks column/row position and emits line/frame markers so the downstream stage can clear its previous-pixel history at line starts.
- Two-stage pipeline with ready/valid flow control.

Parameters:
- H_PIX, 640, active pixels per line (>=2)
- V_PIX, 480, active lines per frame (>=1)
- W_R, 77, red weight (8-bit unsigned)
- W_G, 150, green weight (8-bit unsigned)
- W_B, 29, blue weight (8-bit unsigned); W_R+W_G+W_B must equal 256

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- pix_in  in  24  RGB pixel, [23:16]=R, [15:8]=G, [7:0]=B
- in_valid  in  1  pix_in valid
- sof_in  in  1  with in_valid: this pixel is (col 0, row 0); resynchronises counters
- in_ready  out  1  block accepts pix_in this cycle
- pix_out  out  24  {Y,Y,Y} gray pixel
- out_valid  out  1  pix_out valid
- out_ready  in  1  downstream accepts pix_out
- sol  out  1  pix_out is column 0
- eol  out  1  pix_out is column H_PIX-1
- sof  out  1  pix_out is column 0, row 0
- eof  out  1  pix_out is column H_PIX-1, row V_PIX-1

Behaviour:
- Reset (sync, rst=1 at posedge): pix_out=0, out_valid=0, sol/eol/sof/eof=0, col=0, row=0, both pipe stages invalid. in_ready=1 the cycle after reset.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - Accept when in_valid & in_ready.
  - When stall=1, all pipe registers, counters and outputs hold exactly.
  - When stall=0, the pipeline advances every cycle; bubbles propagate and are not compressed.
- Stage 1 (on advance): s1_valid <= accept; register pR=R*W_R, pG=G*W_G, pB=B*W_B (16-bit each), plus the position flags for the accepted pixel.
- Stage 2 (on advance): out_valid <= s1_valid; Y = (pR+pG+pB)[15:8], truncation with no rounding. The sum fits in 16 bits (max 65280). pix_out <= {Y,Y,Y}; flags forwarded.
- Latency: an accepted pixel appears on pix_out 2 cycles later absent stalls. Throughput: 1 pixel/cycle.
- Position counters (sub-module):
  - On accept: pixel position is (0,0) if sof_in=1, else (col,row).
  - Next col = pos_col+1, wrapping to 0 at H_PIX-1.
  - On that wrap, row = pos_row+1, wrapping to 0 at V_PIX-1.
  - Flags are derived from the pixel position, not from the next value.
- sof_in mid-line: the current pixel is forced to (0,0); sof and sol are asserted for it; the partial line is simply abandoned, with no error output.
- Outputs are registered and valid only while out_valid=1; when out_valid=0, flag outputs are 0.
- rst while stalled or mid-frame: pipeline is flushed and in-flight pixels are dropped; the next accepted pixel is (0,0) even without sof_in.
- Simultaneous accept and stall release in the same cycle: legal, because in_ready already reflects the release.

Decomposition:
- Package img_pkg:
  - typedef pixel_t (logic [23:0]); typedef gray_t (logic [7:0]).
  - Constants H_PIX_DEF, V_PIX_DEF, W_R_DEF, W_G_DEF, W_B_DEF, shared with the edge detector.
- Sub-module pix_coord_counter #(H_PIX,V_PIX):
  - Inputs: clk, rst, adv, sof_in.
  - Outputs: pos_col, pos_row, sol, eol, sof, eof.
- Top level holds the multiply/sum pipeline and the stall logic.

Test Plan:
- Colour math, out_ready=1: FFFFFF->FFFFFF; FF0000->4C4C4C; 00FF00->959595; 0000FF->1C1C1C; 000000->000000; each arrives exactly 2 cycles after accept.
- Markers with H_PIX=4, V_PIX=2, 8 back-to-back pixels, first with sof_in=1:
  - sol on pixels 0 and 4; eol on pixels 3 and 7; sof on pixel 0 only; eof on pixel 7 only.
  - Pixel 8 wraps to sof.
- Backpressure: stream 5 pixels, hold out_ready=0 for 3 cycles after the first out_valid:
  - pix_out and flags stay constant; in_ready=0 during the hold.
  - No pixel is lost or duplicated; order is preserved.
- Bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed 2 cycles; the column counter advances only twice.
- sof_in at column 2 of row 1 -> that pixel reports col 0 row 0 with sof=1 and sol=1; the following pixel has col 1.
- rst asserted for 1 cycle while out_valid=1 and stalled -> next cycle out_valid=0 and in_ready=1; the next accepted pixel reports sof=1.
